// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM states, opcode/funct fields, ALU f codes and aluop selectors.
package mips_ctrl_pkg;

   localparam int OP_W    = 6;
   localparam int FUNCT_W = 6;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: aluop + funct -> ALU f code.
// funct_valid flags the supported R-type functs independently of aluop.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t             aluop,
   input  logic [FUNCT_W-1:0] funct,
   output logic [2:0]         alucontrol,
   output logic               funct_valid
);

   logic [2:0] funct_f;

   always_comb begin
      funct_f     = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  funct_f = ALU_ADD;
         FN_SUB:  funct_f = ALU_SUB;
         FN_AND:  funct_f = ALU_AND;
         FN_OR:   funct_f = ALU_OR;
         FN_SLT:  funct_f = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

   always_comb begin
      case (aluop)
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: alucontrol = funct_f;
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller (Moore FSM) driving datapath selects and enables.
// Define BNE_EN to accept bne (op 000101) as a branch taken on ~zero.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   output logic [2:0]         alucontrol,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic               iord,
   output logic               irwrite,
   output logic               memwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic [1:0]         pcsrc,
   output logic               pcen,
   output logic               illegal_op
);

   state_t     state;
   state_t     dec_state;
   aluop_t     aluop;
   logic       funct_valid;
   logic       op_legal;
   logic       taken;
   logic       pcwrite, branch;
   logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;

   mips_alu_decoder u_aludec (
      .aluop       (aluop),
      .funct       (funct),
      .alucontrol  (alucontrol),
      .funct_valid (funct_valid)
   );

   always_comb begin
      case (op)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
         OP_RTYPE: op_legal = funct_valid;
`ifdef BNE_EN
         OP_BNE:   op_legal = 1'b1;
`endif
         default:  op_legal = 1'b0;
      endcase
   end

`ifdef BNE_EN
   assign taken = (op == OP_BNE) ? ~zero : zero;
`else
   assign taken = zero;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               if (!op_legal) state <= S_FETCH;
               else case (op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_EXECUTE;
                  OP_ADDI:      state <= S_ADDIEX;
                  OP_J:         state <= S_JUMP;
                  default:      state <= S_BRANCH;
               endcase
            end
            S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state <= S_MEMWB;
            S_EXECUTE: state <= S_ALUWB;
            S_ADDIEX:  state <= S_ADDIWB;
            default:   state <= S_FETCH;
         endcase
      end
   end

   // While reset is high, outputs show FETCH selects with every enable gated off.
   always_comb begin
      dec_state  = reset ? S_FETCH : state;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      iord       = 1'b0;
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      aluop      = ALUOP_ADD;
      illegal_s  = 1'b0;
      case (dec_state)
         S_FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
         end
         S_DECODE: begin
            alusrcb   = 2'b11;
            illegal_s = ~op_legal;
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIWB: regwrite_s = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign irwrite    = irwrite_s  & ~reset;
   assign memwrite   = memwrite_s & ~reset;
   assign regwrite   = regwrite_s & ~reset;
   assign illegal_op = illegal_s  & ~reset;
   assign pcen       = (pcwrite | (branch & taken)) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; outputs are packed
// into one 16-bit word and compared per cycle against hand-derived state words.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic [2:0] alucontrol;
   logic       alusrca, iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcen, illegal_op;
   logic [1:0] alusrcb, pcsrc;

   int vectors = 0;
   int miscompares = 0;

   mips_multicycle_ctrl #(.OP_W(6), .FUNCT_W(6)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
      .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcsrc, pcen, illegal_op}
   localparam logic [15:0] W_RST  = 16'b010_0_01_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] W_FET  = 16'b010_0_01_0_1_0_0_0_0_00_1_0;
   localparam logic [15:0] W_DEC  = 16'b010_0_11_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] W_DECI = 16'b010_0_11_0_0_0_0_0_0_00_0_1;
   localparam logic [15:0] W_MADR = 16'b010_1_10_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] W_MRD  = 16'b010_0_00_1_0_0_0_0_0_00_0_0;
   localparam logic [15:0] W_MWB  = 16'b010_0_00_0_0_0_0_1_1_00_0_0;
   localparam logic [15:0] W_MWR  = 16'b010_0_00_1_0_1_0_0_0_00_0_0;
   localparam logic [15:0] W_AWB  = 16'b010_0_00_0_0_0_1_0_1_00_0_0;
   localparam logic [15:0] W_BRT  = 16'b110_1_00_0_0_0_0_0_0_01_1_0;
   localparam logic [15:0] W_BRN  = 16'b110_1_00_0_0_0_0_0_0_01_0_0;
   localparam logic [15:0] W_IWB  = 16'b010_0_00_0_0_0_0_0_1_00_0_0;
   localparam logic [15:0] W_JMP  = 16'b010_0_00_0_0_0_0_0_0_10_1_0;
   localparam logic [12:0] W_EXLO = 13'b1_00_0_0_0_0_0_0_00_0_0;

   function automatic logic [15:0] outs();
      return {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regdst,
              memtoreg, regwrite, pcsrc, pcen, illegal_op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] e[5];
      reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (outs() !== W_RST) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d got %b exp %b", i, outs(), W_RST);
         end
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (outs() !== W_FET) begin
         miscompares++;
         $display("FAIL reset_release got %b exp %b", outs(), W_FET);
      end
      // sw up to MEMWR, then reset mid-instruction for two edges
      op = 6'b101011;
      e = '{W_DEC, W_MADR, W_MWR, W_RST, W_RST};
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (outs() !== e[i]) begin
            miscompares++;
            $display("FAIL reset_sw_pre cyc%0d got %b exp %b", i, outs(), e[i]);
         end
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (outs() !== W_RST) begin
         miscompares++;
         $display("FAIL reset_in_memwr got %b exp %b", outs(), W_RST);
      end
      for (int i = 3; i < 5; i++) begin
         tick();
         vectors++;
         if (outs() !== e[i]) begin
            miscompares++;
            $display("FAIL reset_mid cyc%0d got %b exp %b", i, outs(), e[i]);
         end
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (outs() !== W_FET || alucontrol !== 3'b010) begin
         miscompares++;
         $display("FAIL reset_first_fetch got %b exp %b", outs(), W_FET);
      end
   endtask

   task automatic test_sw();
      logic [15:0] e[4];
      op = 6'b101011;
      e = '{W_DEC, W_MADR, W_MWR, W_FET};
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (outs() !== e[i]) begin
            miscompares++;
            $display("FAIL sw cyc%0d got %b exp %b", i, outs(), e[i]);
         end
      end
   endtask

   task automatic test_lw();
      logic [15:0] e[5];
      op = 6'b100011;
      e = '{W_DEC, W_MADR, W_MRD, W_MWB, W_FET};
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (outs() !== e[i]) begin
            miscompares++;
            $display("FAIL lw cyc%0d got %b exp %b", i, outs(), e[i]);
         end
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  fn[5];
      logic [2:0]  f[5];
      logic [15:0] e[4];
      fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      f  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      op = 6'b000000;
      for (int k = 0; k < 5; k++) begin
         funct = fn[k];
         e = '{W_DEC, {f[k], W_EXLO}, W_AWB, W_FET};
         for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (outs() !== e[i]) begin
               miscompares++;
               $display("FAIL rtype_%b cyc%0d got %b exp %b", fn[k], i, outs(), e[i]);
            end
         end
      end
      funct = 6'b000111;
      e = '{W_DECI, W_FET, W_FET, W_FET};
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (outs() !== e[i]) begin
            miscompares++;
            $display("FAIL rtype_badfunct cyc%0d got %b exp %b", i, outs(), e[i]);
         end
      end
      funct = 6'b000000;
   endtask

   task automatic test_branch(input logic [5:0] opc, input logic want_on_zero, input string nm);
      op = opc;
      tick();
      vectors++;
      if (outs() !== W_DEC) begin
         miscompares++;
         $display("FAIL %s_decode got %b exp %b", nm, outs(), W_DEC);
      end
      tick();
      zero = 1'b1;
      #1;
      vectors++;
      if (outs() !== (want_on_zero ? W_BRT : W_BRN)) begin
         miscompares++;
         $display("FAIL %s_zero1 got %b exp %b", nm, outs(), want_on_zero ? W_BRT : W_BRN);
      end
      zero = 1'b0;
      #1;
      vectors++;
      if (outs() !== (want_on_zero ? W_BRN : W_BRT)) begin
         miscompares++;
         $display("FAIL %s_zero0 got %b exp %b", nm, outs(), want_on_zero ? W_BRN : W_BRT);
      end
      tick();
      vectors++;
      if (outs() !== W_FET) begin
         miscompares++;
         $display("FAIL %s_after got %b exp %b", nm, outs(), W_FET);
      end
   endtask

   task automatic test_bne();
`ifdef BNE_EN
      test_branch(6'b000101, 1'b0, "bne");
`else
      op = 6'b000101;
      tick();
      vectors++;
      if (outs() !== W_DECI) begin
         miscompares++;
         $display("FAIL bne_illegal got %b exp %b", outs(), W_DECI);
      end
      tick();
      vectors++;
      if (outs() !== W_FET) begin
         miscompares++;
         $display("FAIL bne_next got %b exp %b", outs(), W_FET);
      end
`endif
   endtask

   task automatic test_j_addi();
      logic [15:0] ej[3];
      logic [15:0] ea[4];
      op = 6'b000010;
      ej = '{W_DEC, W_JMP, W_FET};
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (outs() !== ej[i]) begin
            miscompares++;
            $display("FAIL j cyc%0d got %b exp %b", i, outs(), ej[i]);
         end
      end
      op = 6'b001000;
      ea = '{W_DEC, W_MADR, W_IWB, W_FET};
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (outs() !== ea[i]) begin
            miscompares++;
            $display("FAIL addi cyc%0d got %b exp %b", i, outs(), ea[i]);
         end
      end
   endtask

   task automatic test_back_to_back_illegal();
      op = 6'b111111;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (outs() !== W_DECI) begin
            miscompares++;
            $display("FAIL illegal_op_pulse rep%0d got %b exp %b", i, outs(), W_DECI);
         end
         tick();
         vectors++;
         if (outs() !== W_FET) begin
            miscompares++;
            $display("FAIL illegal_op_next rep%0d got %b exp %b", i, outs(), W_FET);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_lw();
      test_rtype();
      test_branch(6'b000100, 1'b1, "beq");
      test_bne();
      test_j_addi();
      test_back_to_back_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
